universal_shift_reg: RTL and testbench

Parametrised N-bit universal register built on the team's flip-flop storage level: parallel load, logical shift, rotate, optional up/down count, and a counted burst-shift sequencer with a BUSY/DONE handshake. It replaces ad-hoc chains of single-bit flip-flops wherever a datapath needs a serialiser, deserialiser or small counter.

---
 rtl/usr_pkg.sv | 28 ++
 rtl/usr_next_value.sv | 40 ++++
 rtl/universal_shift_reg.sv | 118 +++++++++++
 tb/tb_universal_shift_reg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
//------------------------------------------------------------------------------
// Module   : usr_pkg
// Brief    : Mode codes and burst FSM state encoding for universal_shift_reg.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package usr_pkg;

    typedef enum logic [2:0] {
        USR_HOLD   = 3'b000,
        USR_SHR    = 3'b001,
        USR_SHL    = 3'b010,
        USR_LOAD   = 3'b011,
        USR_ROR    = 3'b100,
        USR_ROL    = 3'b101,
        USR_CNT_UP = 3'b110,
        USR_CNT_DN = 3'b111
    } usr_mode_e;

    typedef enum logic [0:0] {
        USR_IDLE  = 1'b0,
        USR_BURST = 1'b1
    } usr_state_e;

endpackage

`default_nettype wire

// File: rtl/usr_next_value.sv
//------------------------------------------------------------------------------
// Module   : usr_next_value
// Brief    : Combinational next-Q function of the universal shift register.
//            Count modes are compiled only when USR_COUNT_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module usr_next_value
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  usr_mode_e        i_mode,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin_msb,
    input  logic             i_sin_lsb,
    output logic [WIDTH-1:0] o_q_next
);

    always_comb begin
        o_q_next = i_q;
        case (i_mode)
            USR_SHR:    o_q_next = {i_sin_msb, i_q[WIDTH-1:1]};
            USR_SHL:    o_q_next = {i_q[WIDTH-2:0], i_sin_lsb};
            USR_LOAD:   o_q_next = i_d;
            USR_ROR:    o_q_next = {i_q[0], i_q[WIDTH-1:1]};
            USR_ROL:    o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
`ifdef USR_COUNT_EN
            USR_CNT_UP: o_q_next = i_q + WIDTH'(1);
            USR_CNT_DN: o_q_next = i_q - WIDTH'(1);
`endif
            default:    o_q_next = i_q;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/universal_shift_reg.sv
//------------------------------------------------------------------------------
// Module   : universal_shift_reg
// Brief    : N-bit load/shift/rotate/count register with a counted burst
//            sequencer and BUSY/DONE handshake. Optional macro: USR_COUNT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               LEN_W       = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN_MSB,
    input  logic             SIN_LSB,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_neg,
    output logic             SOUT_LSB,
    output logic             SOUT_MSB,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [LEN_W-1:0] c_len_max = LEN_W'(WIDTH);

    usr_state_e       r_state,  w_state_next;
    usr_mode_e        r_mode,   w_mode_next;
    logic [LEN_W-1:0] r_count,  w_count_next;
    logic [WIDTH-1:0] r_q,      w_q_next;
    logic             r_done,   w_done_next;
    logic [WIDTH-1:0] w_op_result;
    logic [LEN_W-1:0] w_len_clamped;
    usr_mode_e        w_op_mode;

    assign w_len_clamped = (LEN > c_len_max) ? c_len_max : LEN;
    // Live MODE drives the datapath only while idle; a burst uses its latched copy.
    assign w_op_mode     = (r_state == USR_BURST) ? r_mode : usr_mode_e'(MODE);

    usr_next_value #(
        .WIDTH (WIDTH)
    ) u_next_value (
        .i_mode    (w_op_mode),
        .i_q       (r_q),
        .i_d       (D),
        .i_sin_msb (SIN_MSB),
        .i_sin_lsb (SIN_LSB),
        .o_q_next  (w_op_result)
    );

    always_comb begin
        w_state_next = r_state;
        w_mode_next  = r_mode;
        w_count_next = r_count;
        w_q_next     = r_q;
        w_done_next  = 1'b0;
        if (EN) begin
            case (r_state)
                USR_IDLE: begin
                    if (START) begin
                        if (w_len_clamped != '0) begin
                            w_state_next = USR_BURST;
                            w_mode_next  = usr_mode_e'(MODE);
                            w_count_next = w_len_clamped;
                        end else begin
                            w_done_next = 1'b1;
                        end
                    end else begin
                        w_q_next = w_op_result;
                    end
                end
                USR_BURST: begin
                    w_q_next     = w_op_result;
                    w_count_next = r_count - LEN_W'(1);
                    if (r_count == LEN_W'(1)) begin
                        w_state_next = USR_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
                default: w_state_next = USR_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= USR_IDLE;
            r_mode  <= USR_HOLD;
            r_count <= '0;
            r_q     <= RESET_VALUE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mode  <= w_mode_next;
            r_count <= w_count_next;
            r_q     <= w_q_next;
            r_done  <= w_done_next;
        end
    end

    assign Q        = r_q;
    assign Q_neg    = ~r_q;
    assign SOUT_LSB = r_q[0];
    assign SOUT_MSB = r_q[WIDTH-1];
    assign BUSY     = (r_state == USR_BURST);
    assign DONE     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_universal_shift_reg
// Brief    : Directed self-checking bench for universal_shift_reg (WIDTH=8).
//            Count expectations follow USR_COUNT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             EN;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SIN_MSB;
    logic             SIN_LSB;
    logic             START;
    logic [LEN_W-1:0] LEN;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_neg;
    logic             SOUT_LSB;
    logic             SOUT_MSB;
    logic             BUSY;
    logic             DONE;

    int n_tests = 0;
    int n_fail  = 0;

    universal_shift_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (8'h00)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .EN       (EN),
        .MODE     (MODE),
        .D        (D),
        .SIN_MSB  (SIN_MSB),
        .SIN_LSB  (SIN_LSB),
        .START    (START),
        .LEN      (LEN),
        .Q        (Q),
        .Q_neg    (Q_neg),
        .SOUT_LSB (SOUT_LSB),
        .SOUT_MSB (SOUT_MSB),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] val);
        MODE  = 3'b011;
        D     = val;
        START = 1'b0;
        step();
        MODE  = 3'b000;
    endtask

    initial begin
        RST_N = 1'b0; EN = 1'b0; MODE = 3'b000; D = '0;
        SIN_MSB = 1'b0; SIN_LSB = 1'b0; START = 1'b0; LEN = '0;
        #1;
        check_value("rst_q",     Q,     8'h00);
        check_value("rst_qneg",  Q_neg, 8'hFF);
        check_value("rst_busy",  BUSY,  0);
        check_value("rst_done",  DONE,  0);
        step();
        RST_N = 1'b1;
        EN    = 1'b1;

        // Load and shift
        load(8'hA5);
        check_value("load_a5", Q, 8'hA5);
        MODE = 3'b001; SIN_MSB = 1'b1;
        step();
        check_value("shr_q",    Q,        8'hD2);
        check_value("shr_sout", SOUT_LSB, 0);
        check_value("shr_msb",  SOUT_MSB, 1);
        check_value("shr_qneg", Q_neg,    8'h2D);
        MODE = 3'b010; SIN_LSB = 1'b1;
        step();
        check_value("shl_q", Q, 8'hA5);

        // Burst rotate-left LEN=3
        load(8'h81);
        MODE = 3'b101; START = 1'b1; LEN = 3;
        step();
        check_value("rol_acc_q",    Q,    8'h81);
        check_value("rol_acc_busy", BUSY, 1);
        START = 1'b0; MODE = 3'b011; D = 8'h55;
        step();
        check_value("rol1_q", Q, 8'h03);
        check_value("rol1_busy", BUSY, 1);
        check_value("rol1_done", DONE, 0);
        step();
        check_value("rol2_q", Q, 8'h06);
        step();
        check_value("rol3_q",    Q,    8'h0C);
        check_value("rol3_busy", BUSY, 0);
        check_value("rol3_done", DONE, 1);
        MODE = 3'b000;
        step();
        check_value("rol_done_end", DONE, 0);
        check_value("rol_hold_q",   Q,    8'h0C);

        // Burst rotate-right with an EN pause
        MODE = 3'b100; START = 1'b1; LEN = 4;
        step();
        START = 1'b0; MODE = 3'b000;
        step();
        check_value("ror1_q", Q, 8'h06);
        EN = 1'b0;
        step();
        step();
        check_value("pause_q",    Q,    8'h06);
        check_value("pause_busy", BUSY, 1);
        check_value("pause_done", DONE, 0);
        EN = 1'b1;
        step();
        check_value("ror2_q", Q, 8'h03);
        step();
        check_value("ror3_q", Q, 8'h81);
        check_value("ror3_busy", BUSY, 1);
        step();
        check_value("ror4_q",    Q,    8'hC0);
        check_value("ror4_busy", BUSY, 0);
        check_value("ror4_done", DONE, 1);

        // LEN=0 start
        MODE = 3'b011; D = 8'hFF; START = 1'b1; LEN = 0;
        step();
        check_value("len0_q",    Q,    8'hC0);
        check_value("len0_done", DONE, 1);
        check_value("len0_busy", BUSY, 0);
        START = 1'b0; MODE = 3'b000;
        step();
        check_value("len0_done_end", DONE, 0);

        // LEN above WIDTH clamps to WIDTH shifts
        MODE = 3'b001; SIN_MSB = 1'b0; START = 1'b1; LEN = 15;
        step();
        START = 1'b0; MODE = 3'b000;
        for (int i = 0; i < WIDTH - 1; i++) step();
        check_value("clamp_busy_last", BUSY, 1);
        check_value("clamp_q_last",    Q,    8'h01);
        step();
        check_value("clamp_q",    Q,    8'h00);
        check_value("clamp_done", DONE, 1);
        check_value("clamp_busy", BUSY, 0);

        // Count wrap
        load(8'h00);
        MODE = 3'b111;
        step();
`ifdef USR_COUNT_EN
        check_value("cnt_dn_wrap", Q, 8'hFF);
`else
        check_value("cnt_dn_off", Q, 8'h00);
`endif
        load(8'hFF);
        MODE = 3'b110;
        step();
`ifdef USR_COUNT_EN
        check_value("cnt_up_wrap", Q, 8'h00);
`else
        check_value("cnt_up_off", Q, 8'hFF);
`endif

        // Reset mid-burst
        load(8'h3C);
        MODE = 3'b001; SIN_MSB = 1'b0; START = 1'b1; LEN = 4;
        step();
        START = 1'b0; MODE = 3'b000;
        step();
        step();
        check_value("mid_q", Q, 8'h0F);
        #2 RST_N = 1'b0;
        #1;
        check_value("abort_q",    Q,    8'h00);
        check_value("abort_busy", BUSY, 0);
        step();
        RST_N = 1'b1;
        step();
        check_value("abort_done1", DONE, 0);
        check_value("abort_busy1", BUSY, 0);
        step();
        check_value("abort_done2", DONE, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
